// File: rtl/exit_gate_ctrl.sv
// +----------------------------------------------------------------------+
// | exit_gate_ctrl: exit barrier sequencing and lot occupancy counter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module exit_gate_ctrl #(
  parameter int MAX_CARS    = 10,
  parameter int CNT_W       = 4,
  parameter int PAY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             car,
  input  logic             in_sens,
  input  logic             out_sens,
  input  logic             paid,
  input  logic             entry_done,
  output logic             gate,
  output logic             exit_done,
  output logic             alarm,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int TMR_W = (PAY_TIMEOUT > 2) ? $clog2(PAY_TIMEOUT) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_PAY = 2'd1;
  localparam logic [1:0] ST_OPEN     = 2'd2;
  localparam logic [1:0] ST_CLEAR    = 2'd3;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PAY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CARS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_q, gate_d;
  logic             exit_done_q, exit_done_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic empty_w;
  assign empty_w = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    alarm_d     = 1'b0;
    exit_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // An empty lot cannot have a car leaving it; ignore the sensors.
        if (car && in_sens && !empty_w) begin
          state_d = ST_WAIT_PAY;
          timer_d = '0;
        end
      end
      ST_WAIT_PAY: begin
        if (!car) begin
          state_d = ST_IDLE;
        end else if (paid) begin
          state_d = ST_OPEN;
        end else if (timer_q == TMR_LAST) begin
          state_d = ST_IDLE;
          alarm_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_OPEN: begin
        if (out_sens) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!out_sens) begin
          state_d     = ST_IDLE;
          exit_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gate_d = (state_d == ST_OPEN) || (state_d == ST_CLEAR);
  end

  // The registered exit pulse feeds the counter, so the decrement lands one edge later.
  always_comb begin
    count_d = count_q;
    if (entry_done && !exit_done_q) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
    end else if (exit_done_q && !entry_done) begin
      if (count_q != '0) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      gate_q      <= 1'b0;
      exit_done_q <= 1'b0;
      alarm_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      gate_q      <= gate_d;
      exit_done_q <= exit_done_d;
      alarm_q     <= alarm_d;
      count_q     <= count_d;
    end
  end

  assign gate      = gate_q;
  assign exit_done = exit_done_q;
  assign alarm     = alarm_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_MAX);
  assign empty     = empty_w;

endmodule

`default_nettype wire

// File: tb/tb_exit_gate_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_exit_gate_ctrl: directed stimulus checked against a lot model      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_exit_gate_ctrl;

  localparam int MAX_CARS    = 10;
  localparam int CNT_W       = 4;
  localparam int PAY_TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst_n, car, in_sens, out_sens, paid, entry_done;
  logic             gate, exit_done, alarm, full, empty;
  logic [CNT_W-1:0] count;

  int errors = 0;
  int checks = 0;

  exit_gate_ctrl #(
    .MAX_CARS(MAX_CARS), .CNT_W(CNT_W), .PAY_TIMEOUT(PAY_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .car(car), .in_sens(in_sens),
    .out_sens(out_sens), .paid(paid), .entry_done(entry_done),
    .gate(gate), .exit_done(exit_done), .alarm(alarm),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Lot model: phase 0 idle, 1 awaiting payment, 2 barrier up, 3 car past barrier.
  int m_phase, m_waited, m_count;
  bit m_gate, m_exit, m_alarm, m_valid = 1'b0;

  always @(posedge clk) begin
    int ph, w, c;
    bit ex, al;
    if (!rst_n) begin
      m_phase <= 0; m_waited <= 0; m_count <= 0;
      m_gate <= 0; m_exit <= 0; m_alarm <= 0; m_valid <= 1'b1;
    end else if (m_valid) begin
      ph = m_phase; w = m_waited; ex = 0; al = 0;
      c = m_count + (entry_done ? 1 : 0) - (m_exit ? 1 : 0);
      if (c > MAX_CARS) c = MAX_CARS;
      if (c < 0) c = 0;
      case (m_phase)
        0: if (car && in_sens && m_count > 0) begin ph = 1; w = 0; end
        1: begin
          if (!car) ph = 0;
          else if (paid) ph = 2;
          else begin
            w = w + 1;
            if (w == PAY_TIMEOUT) begin ph = 0; al = 1; end
          end
        end
        2: if (out_sens) ph = 3;
        default: if (!out_sens) begin ph = 0; ex = 1; end
      endcase
      m_phase <= ph; m_waited <= w; m_count <= c;
      m_gate <= (ph == 2 || ph == 3); m_exit <= ex; m_alarm <= al;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("gate", 32'(gate), 32'(m_gate));
      check("exit_done", 32'(exit_done), 32'(m_exit));
      check("alarm", 32'(alarm), 32'(m_alarm));
      check("count", 32'(count), 32'(m_count));
      check("full", 32'(full), 32'(m_count == MAX_CARS));
      check("empty", 32'(empty), 32'(m_count == 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; car = 1'b1; in_sens = 1'b1; out_sens = 1'b1;
    paid = 1'b1; entry_done = 1'b1;
    cyc(2);
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_exit_done", 32'(exit_done), 32'd0);
    rst_n = 1'b1; car = 0; in_sens = 0; out_sens = 0; paid = 0; entry_done = 0;
    cyc(1);

    // Normal exit after three entries
    for (int i = 0; i < 3; i++) begin
      entry_done = 1; cyc(1); entry_done = 0; cyc(1);
    end
    check("norm_count3", 32'(count), 32'd3);
    car = 1; in_sens = 1; cyc(1);
    check("norm_wait_gate", 32'(gate), 32'd0);
    paid = 1; cyc(1); paid = 0;
    check("norm_paid_gate", 32'(gate), 32'd1);
    out_sens = 1; cyc(3);
    check("norm_clear_gate", 32'(gate), 32'd1);
    out_sens = 0; car = 0; in_sens = 0; cyc(1);
    check("norm_exit_pulse", 32'(exit_done), 32'd1);
    check("norm_gate_closed", 32'(gate), 32'd0);
    check("norm_count_before", 32'(count), 32'd3);
    cyc(1);
    check("norm_pulse_single", 32'(exit_done), 32'd0);
    check("norm_count2", 32'(count), 32'd2);

    // Timeout with one car in the lot
    do_reset();
    entry_done = 1; cyc(1); entry_done = 0;
    check("to_count1", 32'(count), 32'd1);
    car = 1; in_sens = 1; cyc(1);
    cyc(PAY_TIMEOUT - 1);
    check("to_no_alarm_early", 32'(alarm), 32'd0);
    cyc(1);
    check("to_alarm", 32'(alarm), 32'd1);
    check("to_gate", 32'(gate), 32'd0);
    car = 0; in_sens = 0; paid = 1; cyc(1); paid = 0;
    check("to_alarm_single", 32'(alarm), 32'd0);
    check("to_late_paid", 32'(gate), 32'd0);
    cyc(2);

    // Car drops while waiting to pay
    car = 1; in_sens = 1; cyc(4);
    car = 0; in_sens = 0; cyc(1);
    check("drop_gate", 32'(gate), 32'd0);
    cyc(PAY_TIMEOUT + 2);
    check("drop_no_alarm", 32'(alarm), 32'd0);

    // Payment on the timeout cycle wins
    car = 1; in_sens = 1; cyc(1);
    cyc(PAY_TIMEOUT - 1);
    paid = 1; cyc(1); paid = 0;
    check("race_gate", 32'(gate), 32'd1);
    check("race_alarm", 32'(alarm), 32'd0);
    car = 0; in_sens = 0; out_sens = 1; cyc(1);
    out_sens = 0; cyc(2);
    check("race_empty", 32'(empty), 32'd1);

    // Empty lot ignores a phantom car and payments
    car = 1; in_sens = 1;
    for (int i = 0; i < 4; i++) begin
      paid = 1; cyc(1); paid = 0; cyc(1);
      check("empty_gate", 32'(gate), 32'd0);
    end
    car = 0; in_sens = 0; cyc(1);

    // Saturation, then coincident entry and exit
    entry_done = 1; cyc(12); entry_done = 0;
    check("sat_count", 32'(count), 32'd10);
    check("sat_full", 32'(full), 32'd1);
    car = 1; in_sens = 1; cyc(1);
    paid = 1; cyc(1); paid = 0;
    out_sens = 1; cyc(1);
    out_sens = 0; car = 0; in_sens = 0; cyc(1);
    check("sim_exit_pulse", 32'(exit_done), 32'd1);
    entry_done = 1; cyc(1); entry_done = 0;
    check("sim_count", 32'(count), 32'd10);
    cyc(1);
    check("sim_count_hold", 32'(count), 32'd10);

    // Reset while the barrier is open
    car = 1; in_sens = 1; cyc(1);
    paid = 1; cyc(1); paid = 0;
    check("rstopen_gate_up", 32'(gate), 32'd1);
    rst_n = 0; cyc(1);
    check("rstopen_gate", 32'(gate), 32'd0);
    check("rstopen_count", 32'(count), 32'd0);
    rst_n = 1; car = 0; in_sens = 0; cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
